// File: rtl/serial_tx_scheduler.sv
// Serial word scheduler: after a run of COM sync words it streams accepted
// bytes MSB-first, filling any slot without a byte with COM.
module serial_tx_scheduler #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned SYNC_WORDS = 4
) (
    input  logic       clk16f,
    input  logic       reset_L,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active,
    output logic       slot_start
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

    logic [1:0] state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic [7:0] shreg_q,    shreg_d;
    logic       data_out_q, data_out_d;
    logic       active_q,   active_d;
    logic       slot_q,     slot_d;
    logic       boundary_s;
    logic       ready_s;
    logic [7:0] load_word_s;

    assign boundary_s  = (bit_cnt_q == 3'd7);
    assign load_word_s = (ready_s && valid_in) ? data_in : COM;

    // Acceptance window: last bit of an ACTIVE slot or of the final SYNC slot.
    always_comb begin
        ready_s = 1'b0;
        if (boundary_s && enable) begin
            case (state_q)
                ST_ACTIVE: ready_s = 1'b1;
                ST_SYNC:   ready_s = (sync_cnt_q == SYNC_LAST);
                default:   ready_s = 1'b0;
            endcase
        end else begin
            ready_s = 1'b0;
        end
    end

    // Next-state: bit sequencing, word loading at slot boundaries, FSM moves.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = 3'd0;
                sync_cnt_d = 4'd0;
                if (enable) begin
                    state_d    = ST_SYNC;
                    data_out_d = COM[7];
                    shreg_d    = {COM[6:0], 1'b0};
                end else begin
                    state_d    = ST_IDLE;
                    data_out_d = 1'b0;
                    shreg_d    = 8'h00;
                end
            end
            ST_SYNC, ST_ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (!boundary_s) begin
                    data_out_d = shreg_q[7];
                    shreg_d    = {shreg_q[6:0], 1'b0};
                end else if (!enable) begin
                    // The slot has fully drained; stop cleanly on the boundary.
                    state_d    = ST_IDLE;
                    sync_cnt_d = 4'd0;
                    shreg_d    = 8'h00;
                    data_out_d = 1'b0;
                end else begin
                    data_out_d = load_word_s[7];
                    shreg_d    = {load_word_s[6:0], 1'b0};
                    if (state_q == ST_SYNC) begin
                        sync_cnt_d = sync_cnt_q + 4'd1;
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            state_d = ST_SYNC;
                        end
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                bit_cnt_d  = 3'd0;
                sync_cnt_d = 4'd0;
                shreg_d    = 8'h00;
                data_out_d = 1'b0;
            end
        endcase
    end

    // Status flags are decoded from next state so they register in step with it.
    always_comb begin
        active_d = (state_d == ST_ACTIVE);
        slot_d   = (state_d != ST_IDLE) && (bit_cnt_d == 3'd0);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            sync_cnt_q <= 4'd0;
            shreg_q    <= 8'h00;
            data_out_q <= 1'b0;
            active_q   <= 1'b0;
            slot_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            active_q   <= active_d;
            slot_q     <= slot_d;
        end
    end

    assign ready_out  = ready_s;
    assign data_out   = data_out_q;
    assign active     = active_q;
    assign slot_start = slot_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench: stimulus queues the words each slot must carry, a monitor
// reassembles serial slots and compares them in order.
module tb_serial_tx_scheduler;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk16f = 1'b0;
    logic       reset_L;
    logic       enable;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active;
    logic       slot_start;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    serial_tx_scheduler #(.COM(COM), .SYNC_WORDS(4)) dut (
        .clk16f    (clk16f),
        .reset_L   (reset_L),
        .enable    (enable),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .active    (active),
        .slot_start(slot_start)
    );

    always #5 clk16f = ~clk16f;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk16f);
            #1;
        end
    endtask

    // From one cycle before the IDLE->SYNC edge to the last cycle of the 4th COM.
    task automatic sync_seq();
        for (int i = 0; i < 4; i++) exp_q.push_back(COM);
        tick(31);
        chk_bit("sync_ready_early", ready_out, 1'b0);
        chk_bit("sync_active_early", active, 1'b0);
        tick(1);
        chk_bit("sync_ready_last", ready_out, 1'b1);
        chk_bit("sync_active_last", active, 1'b0);
    endtask

    // Monitor: assemble 8 bits starting at slot_start, compare with the queue.
    initial begin
        int         mon_cnt;
        logic [7:0] mon_word;
        mon_cnt  = 0;
        mon_word = 8'h00;
        forever begin
            @(negedge clk16f);
            if (!reset_L) begin
                mon_cnt = 0;
            end else if (mon_cnt == 0) begin
                if (slot_start) begin
                    mon_word = {7'b0000000, data_out};
                    mon_cnt  = 1;
                end
            end else begin
                mon_word = {mon_word[6:0], data_out};
                mon_cnt  = mon_cnt + 1;
                if (mon_cnt == 8) begin
                    mon_cnt = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL word_unexpected: got %h expected none at %0t", mon_word, $time);
                    end else begin
                        chk_word("slot_word", mon_word, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset_L  = 1'b0;
        enable   = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        tick(3);
        chk_bit("rst_data_out", data_out, 1'b0);
        chk_bit("rst_ready", ready_out, 1'b0);
        chk_bit("rst_active", active, 1'b0);
        chk_bit("rst_slot_start", slot_start, 1'b0);

        // Released with enable low: block must stay idle.
        reset_L = 1'b1;
        tick(2);
        chk_bit("idle_slot_start", slot_start, 1'b0);
        chk_bit("idle_data_out", data_out, 1'b0);

        enable = 1'b1;
        sync_seq();
        exp_q.push_back(COM);
        tick(1);
        chk_bit("active_rise", active, 1'b1);
        chk_bit("active_slot_start", slot_start, 1'b1);

        // Offer a word mid-slot (bit_cnt=2): must be ignored.
        tick(2);
        valid_in = 1'b1;
        data_in  = 8'h77;
        #1;
        chk_bit("midslot_ready", ready_out, 1'b0);
        tick(1);
        valid_in = 1'b0;
        tick(4);
        chk_bit("boundary_ready", ready_out, 1'b1);
        valid_in = 1'b1;
        data_in  = 8'hA5;
        exp_q.push_back(8'hA5);
        tick(1);
        valid_in = 1'b0;
        tick(7);
        chk_bit("boundary_ready2", ready_out, 1'b1);
        exp_q.push_back(COM);

        // Back-to-back words, valid held high through the slots.
        tick(8);
        valid_in = 1'b1;
        data_in  = 8'h01;
        exp_q.push_back(8'h01);
        tick(8);
        data_in = 8'hFF;
        exp_q.push_back(8'hFF);
        tick(4);
        enable = 1'b0;
        #1;
        chk_bit("glitch_ready", ready_out, 1'b0);
        tick(1);
        enable = 1'b1;
        tick(3);
        data_in = 8'h3C;
        exp_q.push_back(8'h3C);
        tick(8);
        data_in = 8'hC3;
        exp_q.push_back(8'hC3);
        tick(1);
        valid_in = 1'b0;

        // Drop enable at bit_cnt=3; slot finishes, then IDLE.
        tick(3);
        enable = 1'b0;
        tick(4);
        #1;
        chk_bit("disable_ready", ready_out, 1'b0);
        valid_in = 1'b1;
        data_in  = 8'h99;
        tick(1);
        valid_in = 1'b0;
        chk_bit("disable_data_out", data_out, 1'b0);
        chk_bit("disable_active", active, 1'b0);
        chk_bit("disable_slot_start", slot_start, 1'b0);
        chk_bit("disable_ready_idle", ready_out, 1'b0);
        tick(3);
        chk_bit("idle_hold_data_out", data_out, 1'b0);

        enable = 1'b1;
        sync_seq();
        exp_q.push_back(COM);
        tick(1);
        chk_bit("reentry_active", active, 1'b1);

        // Reset at bit_cnt=5 of a COM slot (data_out=1 there); aborted slot is retracted.
        tick(5);
        void'(exp_q.pop_back());
        reset_L = 1'b0;
        #1;
        chk_bit("async_rst_data_out", data_out, 1'b0);
        chk_bit("async_rst_active", active, 1'b0);
        chk_bit("async_rst_ready", ready_out, 1'b0);
        chk_bit("async_rst_slot_start", slot_start, 1'b0);
        tick(2);
        chk_bit("rst_hold_data_out", data_out, 1'b0);
        reset_L = 1'b1;
        sync_seq();
        valid_in = 1'b1;
        data_in  = 8'h5A;
        exp_q.push_back(8'h5A);
        tick(1);
        valid_in = 1'b0;
        chk_bit("post_rst_active", active, 1'b1);
        tick(7);
        enable = 1'b0;
        tick(1);
        chk_bit("final_idle_active", active, 1'b0);
        chk_bit("final_idle_data_out", data_out, 1'b0);
        tick(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained: got %0d pending words expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx_scheduler.md
SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

Interface
REQ-001 Parameter: COM, default 8'hBC, idle/comma word sent whenever no data word is accepted.
REQ-002 Parameter: SYNC_WORDS, default 4, number of COM words sent after leaving IDLE before data is accepted; legal range 1..15.
REQ-003 Port: clk16f  input  1  single clock of the block; one serial bit per rising edge.
REQ-004 Port: reset_L  input  1  reset; asynchronous, active-low.
REQ-005 Port: enable  input  1  level; 1 requests transmission, 0 requests return to IDLE at the next word boundary.
REQ-006 Port: data_in  input  8  parallel word offered by the requester.
REQ-007 Port: valid_in  input  1  data_in is valid this cycle.
REQ-008 Port: ready_out  output  1  scheduler accepts data_in at this rising edge when valid_in=1.
REQ-009 Port: data_out  output  1  registered serial bit, MSB first.
REQ-010 Port: active  output  1  high while in ACTIVE state.
REQ-011 Port: slot_start  output  1  high during the cycle in which data_out carries bit 7 of a word.

Function
REQ-012 The FSM SHALL have states IDLE, SYNC and ACTIVE, plus a 3-bit bit counter (bit_cnt) and a sync word counter (sync_cnt).
REQ-013 A word slot SHALL be 8 clk16f cycles; during slot cycle k (k=0..7, bit_cnt=k) data_out SHALL equal W[7-k] of the word W loaded for that slot.
REQ-014 IDLE: data_out=0, bit_cnt=0, ready_out=0, slot_start=0; on an edge with enable=1 the FSM SHALL go to SYNC, load COM and drive data_out=COM[7] from the next cycle (slot cycle 0).
REQ-015 bit_cnt SHALL increment by 1 each edge in SYNC/ACTIVE, wrapping 7->0; the edge with bit_cnt=7 is the slot boundary, at which the next word is loaded.
REQ-016 SYNC: every slot SHALL carry COM; sync_cnt SHALL increment at each slot boundary; at the boundary ending slot number SYNC_WORDS the FSM SHALL go to ACTIVE.
REQ-017 ready_out SHALL be 1 exactly in cycles with bit_cnt=7 and either state=ACTIVE or (state=SYNC and sync_cnt=SYNC_WORDS-1), and enable=1; otherwise 0 (combinational from registered state and enable).
REQ-018 At a slot boundary with ready_out=1 and valid_in=1, data_in SHALL be captured and transmitted in the following slot (latency: data_in[7] on data_out exactly 1 cycle after the accepting edge).
REQ-019 At a slot boundary in ACTIVE without acceptance (valid_in=0), the following slot SHALL carry COM; no data word is lost or duplicated.
REQ-020 valid_in and data_in SHALL be ignored in all cycles where ready_out=0.
REQ-021 enable=0 sampled at a slot boundary in SYNC or ACTIVE SHALL move the FSM to IDLE at that edge (current slot always completes, never truncated); sync_cnt SHALL clear; no word is accepted at that edge.
REQ-022 enable toggling within a slot (not at bit_cnt=7) SHALL have no effect.
REQ-023 active SHALL be 1 exactly while state=ACTIVE; slot_start SHALL be 1 exactly while state is SYNC or ACTIVE and bit_cnt=0.
REQ-024 Re-entry from IDLE SHALL always repeat the full SYNC sequence.

Reset
REQ-025 reset_L=0 SHALL immediately (asynchronously) force state=IDLE, bit_cnt=0, sync_cnt=0, shift register=0, data_out=0, active=0, ready_out=0, slot_start=0.
REQ-026 Reset asserted mid-slot SHALL abort the slot with no further data_out bits; the block SHALL resume only via IDLE->SYNC after reset_L=1.
REQ-027 Release of reset_L SHALL be synchronous to no event; the first state change occurs at the first clk16f edge with reset_L=1 and enable=1.

Verification
REQ-028 Reset release, enable=1, valid_in=0: data_out = 10111100 repeated 4 times (32 cycles), active rises after edge 32, ready_out high only in cycle 32 (bit_cnt=7 of 4th COM) and every 8th cycle thereafter, COM continues.
REQ-029 In ACTIVE, valid_in=1, data_in=8'hA5 held at a ready_out cycle: next 8 data_out bits = 10100101, then COM if valid_in dropped.
REQ-030 Back-to-back words 8'h01, 8'hFF, 8'h3C accepted at consecutive boundaries: 24 contiguous bits 00000001 11111111 00111100, no COM between.
REQ-031 enable dropped at bit_cnt=3 of a data slot: slot completes all 8 bits, FSM returns to IDLE at the boundary, data_out=0, ready_out stays 0; re-enable yields 4 COM words before active.
REQ-032 reset_L pulsed low at bit_cnt=5 in ACTIVE: all outputs 0 within the reset interval without a clock edge; after release with enable=1, full SYNC sequence repeats.
REQ-033 valid_in=1 with ready_out=0 (bit_cnt=2): word not accepted; data_out unchanged sequence.
